// File: rtl/delay_line_writer.sv
// delay_line_writer: four-phase recirculation and slot-write controller for the DL44/DL31 delay-line pair.
// Define DL_WRITE_VERIFY_EN to read back and check each written slot one line period later.
module delay_line_writer #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SA44,
    input  logic              SA31,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [3:0]        WR_DATA44,
    input  logic [3:0]        WR_DATA31,
    output logic              WR_ACK,
    output logic              WR_ERR,
    output logic              BUSY,
    output logic              DL44,
    output logic              DL31,
    output logic              W,
    output logic              X,
    output logic              Y,
    output logic              Z,
    output logic [ADDR_W-1:0] SLOT
);
`ifdef DL_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WAIT_SLOT, WRITE, DONE, VERIFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_SLOT, WRITE, DONE} state_t;
`endif
    state_t state, state_n;
    logic [1:0] ph;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0] d44, d31;
    logic err_q, at_slot, bad_addr, writing;
    assign W = ph == 2'd0;
    assign X = ph == 2'd1;
    assign Y = ph == 2'd2;
    assign Z = ph == 2'd3;
    assign at_slot = SLOT == addr_q;
    assign bad_addr = int'(WR_ADDR) >= LINE_WORDS;
    // the W bit is gated from WAIT_SLOT so DLxx carries the slot's four bits during the WRITE cycles
    assign writing = at_slot && (state == WRITE || (state == WAIT_SLOT && ph == 2'd0));
    assign WR_ACK = state == DONE;
    assign WR_ERR = state == DONE && err_q;
    assign BUSY = state != IDLE;
`ifdef DL_WRITE_VERIFY_EN
    logic seen_q;
    always_ff @(posedge CLK) begin
        if (RST) seen_q <= 1'b0;
        else     seen_q <= state == VERIFY && (seen_q || at_slot);
    end
`endif
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (WR_REQ) state_n = bad_addr ? DONE : WAIT_SLOT;
            WAIT_SLOT: if (at_slot && ph == 2'd0) state_n = WRITE;
`ifdef DL_WRITE_VERIFY_EN
            WRITE:     if (ph == 2'd0) state_n = VERIFY;
            VERIFY:    if (seen_q && !at_slot) state_n = DONE;
`else
            WRITE:     if (ph == 2'd0) state_n = DONE;
`endif
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            ph <= '0;
            SLOT <= '0;
            DL44 <= 1'b0;
            DL31 <= 1'b0;
            addr_q <= '0;
            d44 <= '0;
            d31 <= '0;
            err_q <= 1'b0;
        end else begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) SLOT <= (int'(SLOT) == LINE_WORDS - 1) ? '0 : SLOT + 1'b1;
            DL44 <= writing ? d44[ph] : SA44;
            DL31 <= writing ? d31[ph] : SA31;
            if (state == IDLE && WR_REQ) begin
                addr_q <= WR_ADDR;
                d44 <= WR_DATA44;
                d31 <= WR_DATA31;
                err_q <= bad_addr;
            end
`ifdef DL_WRITE_VERIFY_EN
            else if (state == VERIFY && at_slot && (SA44 != d44[ph] || SA31 != d31[ph])) err_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_delay_line_writer.sv
// tb_delay_line_writer: ideal delay-loop model plus scoreboard of expected WR_ACK cycle and WR_ERR per request.
module tb_delay_line_writer;
    localparam int L = 16;
    localparam int N = 4 * L - 1;
`ifdef DL_WRITE_VERIFY_EN
    localparam int VL = 4 * L;
`else
    localparam int VL = 0;
`endif
    typedef struct {int cyc; logic err;} exp_t;
    logic CLK = 1'b0, RST = 1'b1, WR_REQ = 1'b0;
    logic [7:0] WR_ADDR = '0;
    logic [3:0] WR_DATA44 = '0, WR_DATA31 = '0;
    logic SA44, SA31, WR_ACK, WR_ERR, BUSY, DL44, DL31, W, X, Y, Z;
    logic [7:0] SLOT;
    logic [N-1:0] loop44 = '0, loop31 = '0;
    logic exp44 [0:4*L-1];
    logic exp31 [0:4*L-1];
    logic preload = 1'b0, flip = 1'b0;
    int flip_slot = 0, cyc = 0, prev_pos = 0, n_chk = 0, n_fail = 0;
    int ph, pos;
    exp_t sb[$];

    delay_line_writer #(.LINE_WORDS(L), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .SA44(SA44), .SA31(SA31), .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR),
        .WR_DATA44(WR_DATA44), .WR_DATA31(WR_DATA31), .WR_ACK(WR_ACK), .WR_ERR(WR_ERR), .BUSY(BUSY),
        .DL44(DL44), .DL31(DL31), .W(W), .X(X), .Y(Y), .Z(Z), .SLOT(SLOT)
    );

    assign ph = {30'b0, Y | Z, X | Z};
    assign pos = int'(SLOT) * 4 + ph;
    // preload drives the pattern straight in for one period; afterwards the loop carries it
    assign SA44 = preload ? exp44[pos] : loop44[N-1] ^ (flip && int'(SLOT) == flip_slot && Y);
    assign SA31 = preload ? exp31[pos] : loop31[N-1];

    always #5 CLK = ~CLK;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        prev_pos <= pos;
        loop44 <= RST ? '0 : {loop44[N-2:0], DL44};
        loop31 <= RST ? '0 : {loop31[N-2:0], DL31};
    end

    task automatic do_preload();
        for (int i = 0; i < 4 * L; i++) begin
            exp44[i] = 1'($urandom);
            exp31[i] = 1'($urandom);
        end
        preload = 1'b1;
        repeat (4 * L) @(posedge CLK);
        #1 preload = 1'b0;
    endtask

    task automatic align(input int s, input int p);
        int n = 0;
        while (!(int'(SLOT) == s && ph == p) && n < 4 * L + 4) begin
            @(posedge CLK);
            #1 n++;
        end
    endtask

    task automatic drive(input int a, input logic [3:0] v44, input logic [3:0] v31);
        WR_REQ = 1'b1;
        WR_ADDR = 8'(a);
        WR_DATA44 = v44;
        WR_DATA31 = v31;
    endtask

    task automatic push_exp(input int a, input logic err);
        int d;
        exp_t e;
        if (a >= L) e = '{cyc + 1, 1'b1};
        else begin
            d = (a * 4 - pos + 4 * L) % (4 * L);
            if (d == 0) d = 4 * L;
            e = '{cyc + d + 5 + VL, err};
        end
        sb.push_back(e);
    endtask

    task automatic wait_ack(output int c, output logic e);
        c = -1;
        e = 1'bx;
        for (int i = 0; i < 8 * L + 20; i++) begin
            @(posedge CLK);
            #1;
            if (WR_ACK) begin
                c = cyc;
                e = WR_ERR;
                break;
            end
        end
    endtask

    task automatic commit(input int a, input logic [3:0] v44, input logic [3:0] v31);
        for (int i = 0; i < 4; i++) begin
            exp44[a*4+i] = v44[i];
            exp31[a*4+i] = v31[i];
        end
    endtask

    task automatic sweep(output int bad);
        bad = 0;
        for (int i = 0; i < 4 * L; i++) begin
            @(posedge CLK);
            #1;
            if (DL44 !== exp44[prev_pos] || DL31 !== exp31[prev_pos]) bad++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_chk++;
        if ({W, X, Y, Z, DL44, DL31, WR_ACK, WR_ERR, BUSY} !== 9'b1000_00000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=100000000", {W, X, Y, Z, DL44, DL31, WR_ACK, WR_ERR, BUSY});
        end
        n_chk++;
        if (SLOT !== 8'd0) begin n_fail++; $display("FAIL reset_slot got=%0d exp=0", SLOT); end
        RST = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4 * L; i++) begin
            @(posedge CLK);
            #1;
            n_chk++;
            if ({W, X, Y, Z} !== (4'b1000 >> (i % 4))) begin
                n_fail++;
                $display("FAIL free_phase cycle=%0d got=%b exp=%b", i, {W, X, Y, Z}, 4'b1000 >> (i % 4));
            end
            n_chk++;
            if (SLOT !== 8'((i / 4) % L)) begin
                n_fail++;
                $display("FAIL free_slot cycle=%0d got=%0d exp=%0d", i, SLOT, (i / 4) % L);
            end
            n_chk++;
            if ({DL44, DL31} !== 2'b00) begin
                n_fail++;
                $display("FAIL free_dl cycle=%0d got=%b exp=00", i, {DL44, DL31});
            end
        end
    endtask

    task automatic test_write();
        int c, bad;
        logic e;
        exp_t x;
        do_preload();
        align(0, 0);
        drive(3, 4'b1010, 4'b0101);
        push_exp(3, 1'b0);
        @(posedge CLK);
        #1;
        n_chk++;
        if (BUSY !== 1'b1) begin n_fail++; $display("FAIL write_busy got=%b exp=1", BUSY); end
        wait_ack(c, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL write_ack_cycle got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL write_err got=%b exp=%b", e, x.err); end
        commit(3, 4'b1010, 4'b0101);
        for (int p = 0; p < 3; p++) begin
            sweep(bad);
            n_chk++;
            if (bad !== 0) begin n_fail++; $display("FAIL write_line period=%0d mismatches=%0d exp=0", p, bad); end
        end
    endtask

    task automatic test_latency_bounds();
        int c, bad;
        logic e;
        exp_t x;
        align(6, 3);
        drive(7, 4'b0011, 4'b1110);
        push_exp(7, 1'b0);
        wait_ack(c, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL min_latency_ack got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL min_latency_err got=%b exp=%b", e, x.err); end
        commit(7, 4'b0011, 4'b1110);
        align(9, 0);
        drive(9, 4'b1001, 4'b0110);
        push_exp(9, 1'b0);
        wait_ack(c, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL missed_slot_ack got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL missed_slot_err got=%b exp=%b", e, x.err); end
        commit(9, 4'b1001, 4'b0110);
        sweep(bad);
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL latency_line mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, bad;
        logic e;
        exp_t x;
        do_preload();
        align(14, 3);
        drive(15, 4'b0111, 4'b1000);
        push_exp(15, 1'b0);
        wait_ack(c1, e);
        x = sb.pop_front();
        n_chk++;
        if (c1 !== x.cyc) begin n_fail++; $display("FAIL b2b_first_ack got=%0d exp=%0d", c1, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL b2b_first_err got=%b exp=%b", e, x.err); end
        drive(0, 4'b1101, 4'b0010);
        @(posedge CLK);
        #1 push_exp(0, 1'b0);
        wait_ack(c2, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c2 !== x.cyc) begin n_fail++; $display("FAIL b2b_second_ack got=%0d exp=%0d", c2, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL b2b_second_err got=%b exp=%b", e, x.err); end
        n_chk++;
        if (c2 < 0 || c2 - c1 > 4 * L + 5 + VL) begin
            n_fail++;
            $display("FAIL b2b_spacing got=%0d exp<=%0d", c2 - c1, 4 * L + 5 + VL);
        end
        commit(15, 4'b0111, 4'b1000);
        commit(0, 4'b1101, 4'b0010);
        sweep(bad);
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL b2b_line mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_bad_addr();
        int c, bad;
        logic e;
        exp_t x;
        align(2, 1);
        drive(L, 4'hF, 4'hF);
        push_exp(L, 1'b0);
        wait_ack(c, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL bad_addr_ack got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL bad_addr_err got=%b exp=%b", e, x.err); end
        @(posedge CLK);
        #1;
        n_chk++;
        if ({WR_ACK, WR_ERR, BUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL bad_addr_pulse got=%b exp=000", {WR_ACK, WR_ERR, BUSY});
        end
        sweep(bad);
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL bad_addr_line mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_write();
        int c, bad, n, acks;
        logic e;
        exp_t x;
        align(0, 0);
        drive(5, 4'b1100, 4'b0011);
        push_exp(5, 1'b0);
        n = 0;
        while (!(int'(SLOT) == 5 && Y) && n < 4 * L + 8) begin
            @(posedge CLK);
            #1 n++;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_chk++;
        if ({W, X, Y, Z, DL44, DL31, WR_ACK, WR_ERR, BUSY} !== 9'b1000_00000 || SLOT !== 8'd0) begin
            n_fail++;
            $display("FAIL midwrite_reset got=%b slot=%0d exp=100000000 slot=0",
                     {W, X, Y, Z, DL44, DL31, WR_ACK, WR_ERR, BUSY}, SLOT);
        end
        RST = 1'b0;
        WR_REQ = 1'b0;
        sb.delete();
        acks = 0;
        repeat (4 * L + 8) begin
            @(posedge CLK);
            #1 if (WR_ACK) acks++;
        end
        n_chk++;
        if (acks !== 0) begin n_fail++; $display("FAIL midwrite_no_ack got=%0d exp=0", acks); end
        do_preload();
        align(10, 2);
        drive(11, 4'b0101, 4'b1011);
        push_exp(11, 1'b0);
        wait_ack(c, e);
        WR_REQ = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL after_reset_ack got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL after_reset_err got=%b exp=%b", e, x.err); end
        commit(11, 4'b0101, 4'b1011);
        sweep(bad);
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL after_reset_line mismatches=%0d exp=0", bad); end
    endtask

`ifdef DL_WRITE_VERIFY_EN
    task automatic test_verify_error();
        int c;
        logic e;
        exp_t x;
        flip_slot = 7;
        flip = 1'b1;
        align(0, 0);
        drive(7, 4'b0110, 4'b1001);
        push_exp(7, 1'b1);
        wait_ack(c, e);
        WR_REQ = 1'b0;
        flip = 1'b0;
        x = sb.pop_front();
        n_chk++;
        if (c !== x.cyc) begin n_fail++; $display("FAIL verify_ack got=%0d exp=%0d", c, x.cyc); end
        n_chk++;
        if (e !== x.err) begin n_fail++; $display("FAIL verify_err got=%b exp=%b", e, x.err); end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_write();
        test_latency_bounds();
        test_back_to_back();
        test_bad_addr();
        test_reset_mid_write();
`ifdef DL_WRITE_VERIFY_EN
        test_verify_error();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/delay_line_writer.md
# delay_line_writer

Serializing write/recirculation controller for the LVDC delay-line memory pair (DL44, DL31). Generates the four-phase bit timing (W, X, Y, Z), keeps both lines recirculating by re-gating sensed bits, and, on request, replaces one word slot with new parallel data. Drives the gate inputs that feed the delay-line drivers. The downstream phase-latched sense logic deserializes into PR/MD0/MR0/ACC0 (DL44) and STP/AI0/NU/PQR (DL31).

## Interface
- LINE_WORDS, 16: word slots per line. One word is 4 bits, so line period = 4*LINE_WORDS cycles. Range 2..256.
- ADDR_W, 8: width of WR_ADDR and SLOT.

- CLK  in  1  bit clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SA44  in  1  sensed DL44 output bit.
- SA31  in  1  sensed DL31 output bit.
- WR_REQ  in  1  write request; held high until WR_ACK.
- WR_ADDR  in  ADDR_W  target word slot.
- WR_DATA44  in  4  bits [0..3] = PR, MD0, MR0, ACC0.
- WR_DATA31  in  4  bits [0..3] = STP, AI0, NU, PQR.
- WR_ACK  out  1  one-cycle pulse when the request completes.
- WR_ERR  out  1  one-cycle pulse coincident with WR_ACK on a rejected or failed request.
- BUSY  out  1  high from acceptance through WR_ACK.
- DL44  out  1  registered gate bit to the DL44 driver.
- DL31  out  1  registered gate bit to the DL31 driver.
- W, X, Y, Z  out  1 each  one-hot phase strobes.
- SLOT  out  ADDR_W  current word slot.

## Operation
- Phase counter: W→X→Y→Z→W, one cycle per phase. SLOT increments on Z→W and wraps LINE_WORDS-1→0.
- Bit index follows the phase: W=0, X=1, Y=2, Z=3.
- Recirculation (default): DL44 <= SA44 and DL31 <= SA31 every cycle.
- External loop contract: a bit on DLxx at cycle t returns on SAxx at t+4*LINE_WORDS-1, so a recirculated bit re-enters with a period of exactly 4*LINE_WORDS cycles.
- State machine:
  - IDLE: if WR_REQ=1, capture WR_ADDR and both data nibbles and set BUSY=1.
    - WR_ADDR >= LINE_WORDS: pulse WR_ACK and WR_ERR on the next cycle, then return to IDLE.
    - Otherwise go to WAIT_SLOT.
  - WAIT_SLOT: go to WRITE on the cycle where SLOT==captured addr and phase==W.
  - WRITE: 4 cycles (W..Z). DL44 <= data44[bit index] and DL31 <= data31[bit index]; sensed bits are discarded.
    - After Z, go to DONE (or VERIFY when configured).
  - DONE: pulse WR_ACK for one cycle, clear BUSY, go to IDLE.
- WR_REQ is not sampled outside IDLE.
- After WR_ACK, the requester drops WR_REQ within one cycle; WR_REQ still high in the IDLE cycle after ACK counts as a new request.
- Writing to a slot never disturbs other slots: all non-WRITE cycles recirculate.

## Timing
- Reset values: phase=W (W=1, X=Y=Z=0); SLOT=0; DL44=DL31=0; WR_ACK=WR_ERR=BUSY=0; state IDLE.
- Reset mid-write aborts the operation with no ACK. Line contents are not preserved.
- Gate latency: data for the phase sampled in cycle t appears on DLxx at t+1.
- Write latency from acceptance to WR_ACK:
  - min 6 cycles (slot and phase align immediately);
  - max 4*LINE_WORDS+5 cycles.
- Request accepted in the same cycle that SLOT==addr and phase==W: that slot is missed and the write waits one full line period.
- WR_ACK and WR_ERR are registered and last one cycle.

## Configuration
- DL_WRITE_VERIFY_EN defined: after WRITE, enter VERIFY.
  - Wait until the written slot returns: SAxx in cycles 4*LINE_WORDS-1..4*LINE_WORDS+2 after the first WRITE cycle.
  - Compare the 8 sensed bits with the captured data.
  - Then go to DONE. WR_ERR pulses with WR_ACK on any mismatch.
  - Recirculation continues throughout VERIFY.
  - Latency grows by 4*LINE_WORDS cycles.
- Undefined: no VERIFY state. WR_ERR is asserted only for out-of-range addresses.

## Test plan
- Reset then free-run with the ideal loop model: W/X/Y/Z one-hot rotating; SLOT wraps 15→0 after 64 cycles; DL44=DL31=0 throughout.
- Write slot 3, data44=4'b1010, data31=4'b0101, accepted at SLOT=0 phase W: DL44 shows 0,1,0,1 during slot 3; WR_ACK at the predicted cycle; line content unchanged after 3 further periods.
- Back-to-back writes to slots 15 then 0 with WR_REQ held: both complete; second ACK ≤ 4*LINE_WORDS+5 cycles after the first; all other slots retain preloaded pattern.
- WR_ADDR=16 with LINE_WORDS=16: WR_ACK and WR_ERR pulse 1 cycle after acceptance; no line change.
- RST asserted during WRITE phase Y: next cycle all outputs at reset values, no WR_ACK; a new request afterwards completes normally.
- With DL_WRITE_VERIFY_EN, the loop model flips bit MR0 of the target slot: WR_ACK and WR_ERR together, 4*LINE_WORDS cycles later than the no-error case.
